// File: rtl/ppu_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_arbiter
// Purpose  : Shares the PPU's single 14-bit VRAM port between the render
//            fetch engine (priority) and the CPU PPUDATA path. A starvation
//            counter bounds how long a pending CPU access can be deferred.
//            Optional macro PPU_PALETTE_MIRROR_EN folds palette addresses
//            (3F00-3FFF) onto the 32-byte palette, including the
//            3F10/14/18/1C -> 3F00/04/08/0C aliases.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_arbiter #(
    parameter int RD_LATENCY   = 2,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rnd_req,
    input  logic [13:0] rnd_addr,
    output logic        rnd_ack,
    output logic [7:0]  rnd_data,
    output logic        rnd_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [13:0] addr,
    output logic        write_request,
    output logic        read_request
);

    localparam logic [2:0] c_rd_latency = 3'(RD_LATENCY);
    localparam logic [7:0] c_max_wait   = 8'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2
    } state_t;

    state_t      r_state_q,     w_state_d;
    logic        r_pend_q,      w_pend_d;
    logic        r_cwe_q,       w_cwe_d;
    logic [13:0] r_caddr_q,     w_caddr_d;
    logic [7:0]  r_cwdata_q,    w_cwdata_d;
    logic [7:0]  r_starve_q,    w_starve_d;
    logic [2:0]  r_lat_q,       w_lat_d;
    logic        r_owner_cpu_q, w_owner_cpu_d;
    logic [13:0] r_addr_q,      w_addr_d;
    logic [7:0]  r_data_out_q,  w_data_out_d;
    logic        r_rd_req_q,    w_rd_req_d;
    logic        r_wr_req_q,    w_wr_req_d;
    logic        r_rnd_ack_q,   w_rnd_ack_d;
    logic [7:0]  r_rnd_data_q,  w_rnd_data_d;
    logic        r_rnd_valid_q, w_rnd_valid_d;
    logic        r_cpu_busy_q,  w_cpu_busy_d;
    logic [7:0]  r_cpu_rdata_q, w_cpu_rdata_d;
    logic        r_cpu_rvalid_q, w_cpu_rvalid_d;
    logic        w_cpu_grant;
    logic        w_rnd_grant;

    // Palette folding applied to every address just before it is issued.
    function automatic logic [13:0] f_map_addr(input logic [13:0] a);
        logic [13:0] m;
        m = a;
`ifdef PPU_PALETTE_MIRROR_EN
        if (a[13:8] == 6'h3F) begin
            m = {6'h3F, 3'b000, a[4:0]};
            if (a[1:0] == 2'b00) begin
                m[4] = 1'b0;
            end
        end
`endif
        return m;
    endfunction

    // Next-state logic: CPU latch, arbitration, issue and completion.
    always_comb begin
        w_state_d      = r_state_q;
        w_pend_d       = r_pend_q;
        w_cwe_d        = r_cwe_q;
        w_caddr_d      = r_caddr_q;
        w_cwdata_d     = r_cwdata_q;
        w_starve_d     = r_starve_q;
        w_lat_d        = r_lat_q;
        w_owner_cpu_d  = r_owner_cpu_q;
        w_addr_d       = r_addr_q;
        w_data_out_d   = r_data_out_q;
        w_rd_req_d     = 1'b0;
        w_wr_req_d     = 1'b0;
        w_rnd_ack_d    = 1'b0;
        w_rnd_data_d   = r_rnd_data_q;
        w_rnd_valid_d  = 1'b0;
        w_cpu_busy_d   = r_cpu_busy_q;
        w_cpu_rdata_d  = r_cpu_rdata_q;
        w_cpu_rvalid_d = 1'b0;
        w_cpu_grant    = 1'b0;
        w_rnd_grant    = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // Starved CPU first, then render, then any pending CPU access.
                if (r_pend_q && (r_starve_q >= c_max_wait)) begin
                    w_cpu_grant = 1'b1;
                end else if (rnd_req) begin
                    w_rnd_grant = 1'b1;
                end else if (r_pend_q) begin
                    w_cpu_grant = 1'b1;
                end

                if (w_rnd_grant) begin
                    w_addr_d      = f_map_addr(rnd_addr);
                    w_rd_req_d    = 1'b1;
                    w_rnd_ack_d   = 1'b1;
                    w_owner_cpu_d = 1'b0;
                    w_lat_d       = 3'd0;
                    w_state_d     = ST_RD_WAIT;
                end else if (w_cpu_grant) begin
                    w_addr_d      = f_map_addr(r_caddr_q);
                    w_owner_cpu_d = 1'b1;
                    w_pend_d      = 1'b0;
                    if (r_cwe_q) begin
                        w_data_out_d = r_cwdata_q;
                        w_wr_req_d   = 1'b1;
                        w_state_d    = ST_WR;
                    end else begin
                        w_rd_req_d = 1'b1;
                        w_lat_d    = 3'd0;
                        w_state_d  = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // data_in is valid RD_LATENCY cycles after the issue cycle.
                if (r_lat_q == c_rd_latency) begin
                    w_state_d = ST_IDLE;
                    if (r_owner_cpu_q) begin
                        w_cpu_rdata_d  = data_in;
                        w_cpu_rvalid_d = 1'b1;
                        w_cpu_busy_d   = 1'b0;
                    end else begin
                        w_rnd_data_d  = data_in;
                        w_rnd_valid_d = 1'b1;
                    end
                end else begin
                    w_lat_d = r_lat_q + 3'd1;
                end
            end
            ST_WR: begin
                w_state_d    = ST_IDLE;
                w_cpu_busy_d = 1'b0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Starvation counter only runs while a CPU access waits ungranted.
        if (w_cpu_grant) begin
            w_starve_d = 8'd0;
        end else if (r_pend_q && (r_starve_q != 8'hFF)) begin
            w_starve_d = r_starve_q + 8'd1;
        end

        // A new CPU strobe is only accepted when nothing is outstanding.
        if (cpu_req && !r_cpu_busy_q) begin
            w_pend_d     = 1'b1;
            w_cpu_busy_d = 1'b1;
            w_cwe_d      = cpu_we;
            w_caddr_d    = cpu_addr;
            w_cwdata_d   = cpu_wdata;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_pend_q       <= 1'b0;
            r_cwe_q        <= 1'b0;
            r_caddr_q      <= 14'd0;
            r_cwdata_q     <= 8'd0;
            r_starve_q     <= 8'd0;
            r_lat_q        <= 3'd0;
            r_owner_cpu_q  <= 1'b0;
            r_addr_q       <= 14'd0;
            r_data_out_q   <= 8'd0;
            r_rd_req_q     <= 1'b0;
            r_wr_req_q     <= 1'b0;
            r_rnd_ack_q    <= 1'b0;
            r_rnd_data_q   <= 8'd0;
            r_rnd_valid_q  <= 1'b0;
            r_cpu_busy_q   <= 1'b0;
            r_cpu_rdata_q  <= 8'd0;
            r_cpu_rvalid_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pend_q       <= w_pend_d;
            r_cwe_q        <= w_cwe_d;
            r_caddr_q      <= w_caddr_d;
            r_cwdata_q     <= w_cwdata_d;
            r_starve_q     <= w_starve_d;
            r_lat_q        <= w_lat_d;
            r_owner_cpu_q  <= w_owner_cpu_d;
            r_addr_q       <= w_addr_d;
            r_data_out_q   <= w_data_out_d;
            r_rd_req_q     <= w_rd_req_d;
            r_wr_req_q     <= w_wr_req_d;
            r_rnd_ack_q    <= w_rnd_ack_d;
            r_rnd_data_q   <= w_rnd_data_d;
            r_rnd_valid_q  <= w_rnd_valid_d;
            r_cpu_busy_q   <= w_cpu_busy_d;
            r_cpu_rdata_q  <= w_cpu_rdata_d;
            r_cpu_rvalid_q <= w_cpu_rvalid_d;
        end
    end

    assign rnd_ack       = r_rnd_ack_q;
    assign rnd_data      = r_rnd_data_q;
    assign rnd_valid     = r_rnd_valid_q;
    assign cpu_busy      = r_cpu_busy_q;
    assign cpu_rdata     = r_cpu_rdata_q;
    assign cpu_rvalid    = r_cpu_rvalid_q;
    assign data_out      = r_data_out_q;
    assign addr          = r_addr_q;
    assign write_request = r_wr_req_q;
    assign read_request  = r_rd_req_q;

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_vram_arbiter
// Purpose  : Self-checking bench for ppu_vram_arbiter with a memory model and
//            scoreboard queues for issued accesses and returned read data.
//            Honours PPU_PALETTE_MIRROR_EN for expected addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;

    typedef struct packed {
        logic        we;
        logic [13:0] a;
        logic [7:0]  d;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rnd_req = 1'b0;
    logic [13:0] rnd_addr = 14'd0;
    logic        rnd_ack;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = 14'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_busy;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [7:0]  data_in = 8'hEE;
    logic [7:0]  data_out;
    logic [13:0] addr;
    logic        write_request;
    logic        read_request;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:16383];
    int          rd_cd = 0;
    logic [13:0] rd_a  = 14'd0;

    iss_t       rnd_iss_q[$];
    iss_t       cpu_iss_q[$];
    logic [7:0] rnd_dat_q[$];
    logic [7:0] cpu_dat_q[$];

    ppu_vram_arbiter #(.RD_LATENCY(RD_LAT), .CPU_MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_ack(rnd_ack),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .data_in(data_in), .data_out(data_out),
        .addr(addr), .write_request(write_request), .read_request(read_request)
    );

    always #20 clk = ~clk;

    // Address the memory should see for a requested address.
    function automatic logic [13:0] exp_map(input logic [13:0] a);
`ifdef PPU_PALETTE_MIRROR_EN
        logic [4:0] low;
        low = a[4:0];
        if (low[1:0] == 2'b00) low[4] = 1'b0;
        if (a[13:8] == 6'h3F) return {6'h3F, 3'b000, low};
`endif
        return a;
    endfunction

    function automatic logic [43:0] all_outs();
        return {rnd_ack, rnd_data, rnd_valid, cpu_busy, cpu_rdata, cpu_rvalid,
                data_out, addr, write_request, read_request};
    endfunction

    // Memory model plus scoreboard for issued accesses and returned data.
    always @(negedge clk) begin
        if (rd_cd == 1) begin
            data_in = mem[rd_a];
            rd_cd   = 0;
        end else begin
            data_in = 8'hEE;
            if (rd_cd > 1) rd_cd--;
        end
        if (read_request) begin
            rd_a  = addr;
            rd_cd = RD_LAT;
        end
        if (write_request) mem[addr] = data_out;

        if (read_request || write_request || rnd_ack) begin
            checks++;
            if (read_request && write_request) begin
                failures++;
                $display("FAIL strobe_excl: rd=%0b wr=%0b both high", read_request, write_request);
            end else if (rnd_ack) begin
                if (rnd_iss_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_issue: unexpected ack addr=%h, none required", addr);
                end else begin
                    iss_t e;
                    e = rnd_iss_q.pop_front();
                    if (!read_request || addr !== e.a) begin
                        failures++;
                        $display("FAIL rnd_issue: rd=%0b addr=%h, required rd=1 addr=%h", read_request, addr, e.a);
                    end
                end
            end else begin
                if (cpu_iss_q.size() == 0) begin
                    failures++;
                    $display("FAIL cpu_issue: unexpected rd=%0b wr=%0b addr=%h", read_request, write_request, addr);
                end else begin
                    iss_t e;
                    e = cpu_iss_q.pop_front();
                    if (write_request !== e.we || read_request !== !e.we || addr !== e.a ||
                        (e.we && data_out !== e.d)) begin
                        failures++;
                        $display("FAIL cpu_issue: wr=%0b addr=%h dout=%h, required wr=%0b addr=%h dout=%h",
                                 write_request, addr, data_out, e.we, e.a, e.d);
                    end
                end
            end
        end
        if (rnd_valid) begin
            checks++;
            if (rnd_dat_q.size() == 0) begin
                failures++;
                $display("FAIL rnd_data: unexpected rnd_valid data=%h", rnd_data);
            end else begin
                logic [7:0] d;
                d = rnd_dat_q.pop_front();
                if (rnd_data !== d) begin
                    failures++;
                    $display("FAIL rnd_data: got %h required %h", rnd_data, d);
                end
            end
        end
        if (cpu_rvalid) begin
            checks++;
            if (cpu_dat_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_rdata: unexpected cpu_rvalid data=%h", cpu_rdata);
            end else begin
                logic [7:0] d;
                d = cpu_dat_q.pop_front();
                if (cpu_rdata !== d) begin
                    failures++;
                    $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, d);
                end
            end
        end
    end

    function automatic void push_rnd(input logic [13:0] a, input logic with_data);
        iss_t e;
        e.we = 1'b0; e.a = exp_map(a); e.d = 8'd0;
        rnd_iss_q.push_back(e);
        if (with_data) rnd_dat_q.push_back(mem[exp_map(a)]);
    endfunction

    function automatic void push_cpu(input logic we, input logic [13:0] a, input logic [7:0] d);
        iss_t e;
        e.we = we; e.a = exp_map(a); e.d = d;
        cpu_iss_q.push_back(e);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== 44'd0) begin
            failures++;
            $display("FAIL reset_outs: got %h required 0", all_outs());
        end
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            checks++;
            if (all_outs() !== 44'd0) begin
                failures++;
                $display("FAIL idle_outs: cycle %0d got %h required 0", t, all_outs());
            end
        end
    endtask

    // One render read; ack one cycle after request, data RD_LAT+1 after ack.
    task automatic test_render_read(input logic [13:0] a);
        int ack_t = -1, val_t = -1, n_ack = 0, n_val = 0;
        rnd_req = 1'b1; rnd_addr = a;
        push_rnd(a, 1'b1);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (rnd_ack) begin n_ack++; if (ack_t < 0) ack_t = t; rnd_req = 1'b0; end
            if (rnd_valid) begin n_val++; if (val_t < 0) val_t = t; end
        end
        checks++;
        if (ack_t != 1 || n_ack != 1) begin
            failures++;
            $display("FAIL rnd_ack_timing: at %0d count %0d, required at 1 count 1", ack_t, n_ack);
        end
        checks++;
        if (val_t != RD_LAT + 2 || n_val != 1) begin
            failures++;
            $display("FAIL rnd_valid_timing: at %0d count %0d, required at %0d count 1", val_t, n_val, RD_LAT + 2);
        end
    endtask

    task automatic test_cpu_write();
        int wr_t = -1, n_wr = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h23C0; cpu_wdata = 8'h5A;
        push_cpu(1'b1, 14'h23C0, 8'h5A);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (write_request) begin n_wr++; if (wr_t < 0) wr_t = t; end
            if (t == 1) begin
                checks++;
                if (cpu_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_busy_set: got %0b required 1", cpu_busy);
                end
                // Second strobe while busy must be dropped.
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h77;
            end
            if (t == 2) cpu_req = 1'b0;
            if (t == 3) begin
                checks++;
                if (cpu_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL wr_busy_clear: got %0b required 0", cpu_busy);
                end
            end
        end
        checks++;
        if (wr_t != 2 || n_wr != 1) begin
            failures++;
            $display("FAIL wr_strobe: at %0d count %0d, required at 2 count 1", wr_t, n_wr);
        end
    endtask

    task automatic test_cpu_read();
        int rv_t = -1, n_rv = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h23C0;
        push_cpu(1'b0, 14'h23C0, 8'h00);
        cpu_dat_q.push_back(8'h5A);
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            if (t == 1) cpu_req = 1'b0;
            if (cpu_rvalid) begin n_rv++; if (rv_t < 0) rv_t = t; end
            if (t == RD_LAT + 2) begin
                checks++;
                if (cpu_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rd_busy_hold: got %0b required 1", cpu_busy);
                end
            end
            if (t == RD_LAT + 3) begin
                checks++;
                if (cpu_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_busy_clear: got %0b required 0", cpu_busy);
                end
            end
        end
        checks++;
        if (rv_t != RD_LAT + 3 || n_rv != 1) begin
            failures++;
            $display("FAIL cpu_rvalid_timing: at %0d count %0d, required at %0d count 1", rv_t, n_rv, RD_LAT + 3);
        end
        checks++;
        if (cpu_rdata !== 8'h5A) begin
            failures++;
            $display("FAIL cpu_rdata_hold: got %h required 5a", cpu_rdata);
        end
    endtask

    // Render held continuously; CPU read strobed in the first ack cycle C.
    // Pending from C+1, counter = k at C+1+k; arbitration cycles fall every
    // RD_LAT+2 = 4 cycles at C+3, C+7, C+11. Counter is 6 at C+7 and 10 at
    // C+11, so renders issue at C+4 and C+8 and the CPU read issues at C+12.
    task automatic test_starvation();
        int first_ack = -1, between = 0, cpu_iss_t = -1, cpu_rv_t = -1, after_ack = -1;
        logic [13:0] ra;
        ra = 14'h2100;
        rnd_req = 1'b1; rnd_addr = ra;
        push_rnd(ra, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (first_ack > 0 && t == first_ack + 1) cpu_req = 1'b0;
            if (read_request && !rnd_ack && cpu_iss_t < 0) cpu_iss_t = t;
            if (cpu_rvalid && cpu_rv_t < 0) cpu_rv_t = t;
            if (rnd_ack) begin
                if (first_ack < 0) begin
                    first_ack = t;
                    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
                    push_cpu(1'b0, 14'h0010, 8'h00);
                    cpu_dat_q.push_back(mem[exp_map(14'h0010)]);
                end else if (cpu_iss_t < 0) begin
                    between++;
                end else if (after_ack < 0) begin
                    after_ack = t;
                end
                if (after_ack < 0) begin
                    ra = ra + 14'd1;
                    rnd_addr = ra;
                    push_rnd(ra, 1'b1);
                end else begin
                    rnd_req = 1'b0;
                end
            end
        end
        checks++;
        if (between != 2) begin
            failures++;
            $display("FAIL starve_render_count: got %0d required 2", between);
        end
        checks++;
        if (first_ack < 0 || cpu_iss_t != first_ack + 12) begin
            failures++;
            $display("FAIL starve_cpu_issue: at %0d required %0d", cpu_iss_t, first_ack + 12);
        end
        checks++;
        if (cpu_rv_t != cpu_iss_t + RD_LAT + 1 || cpu_iss_t < 0) begin
            failures++;
            $display("FAIL starve_cpu_rvalid: at %0d required %0d", cpu_rv_t, cpu_iss_t + RD_LAT + 1);
        end
        checks++;
        if (after_ack != cpu_rv_t + 1 || cpu_rv_t < 0) begin
            failures++;
            $display("FAIL starve_render_resume: at %0d required %0d", after_ack, cpu_rv_t + 1);
        end
    endtask

    task automatic test_reset_mid_read();
        int n_v = 0;
        rnd_req = 1'b1; rnd_addr = 14'h0155;
        push_rnd(14'h0155, 1'b0);
        @(negedge clk);
        checks++;
        if (rnd_ack !== 1'b1 || read_request !== 1'b1) begin
            failures++;
            $display("FAIL abort_issue: ack=%0b rd=%0b required 1 1", rnd_ack, read_request);
        end
        rnd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (all_outs() !== 44'd0) begin
            failures++;
            $display("FAIL abort_outs: got %h required 0", all_outs());
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (rnd_valid || read_request || write_request) n_v++;
        end
        checks++;
        if (n_v != 0) begin
            failures++;
            $display("FAIL abort_no_valid: %0d activity cycles, required 0", n_v);
        end
        test_render_read(14'h0156);
    endtask

    task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d,
                              input logic [7:0] rd_exp);
        int done_t = -1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        push_cpu(we, a, d);
        if (!we) cpu_dat_q.push_back(rd_exp);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (t == 1) cpu_req = 1'b0;
            if (t > 1 && !cpu_busy && done_t < 0) done_t = t;
        end
        checks++;
        if (done_t < 0) begin
            failures++;
            $display("FAIL cpu_access_done: addr %h never completed, required completion", a);
        end
    endtask

    task automatic test_palette_mirror();
        cpu_access(1'b1, 14'h3F10, 8'h3C, 8'h00);
        cpu_access(1'b0, 14'h3F25, 8'h00, mem[exp_map(14'h3F25)]);
        cpu_access(1'b0, 14'h3F10, 8'h00, 8'h3C);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            logic [13:0] ia;
            ia = 14'(i);
            mem[i] = ia[7:0] ^ {2'b00, ia[13:8]} ^ 8'h3C;
        end
        mem[14'h2000] = 8'hA5;

        test_reset();
        test_render_read(14'h2000);
        test_cpu_write();
        test_cpu_read();
        test_starvation();
        repeat (4) @(negedge clk);
        test_reset_mid_read();
        test_palette_mirror();
        repeat (6) @(negedge clk);

        checks++;
        if (rnd_iss_q.size() != 0 || cpu_iss_q.size() != 0 ||
            rnd_dat_q.size() != 0 || cpu_dat_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: rnd_iss=%0d cpu_iss=%0d rnd_dat=%0d cpu_dat=%0d, required all 0",
                     rnd_iss_q.size(), cpu_iss_q.size(), rnd_dat_q.size(), cpu_dat_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Sequences and shares the PPU's single 14-bit VRAM/pattern memory port between two requesters: the render fetch engine (nametable, attribute and pattern fetches) and the CPU PPUDATA path (#2007 reads and writes).
- Sits between the register file, the render pipeline and the external memory interface of the PPU top level.
- The render path has priority. A starvation counter bounds CPU latency.

Parameters:
- RD_LATENCY, 2: cycles from the read_request cycle to the cycle in which data_in is valid. Legal range is 1..7.
- CPU_MAX_WAIT, 8: number of pending-but-ungranted cycles after which the CPU wins the next arbitration. Legal range is 1..255.

Ports:
- clk, input, 1: system clock, 25 MHz. Single clock domain.
- rst, input, 1: synchronous, active-high reset.
- rnd_req, input, 1: render read request. Level signal, held until rnd_ack.
- rnd_addr, input, 14: render read address. Must be stable while rnd_req is high and not yet acked.
- rnd_ack, output, 1: one-cycle pulse marking the cycle in which the render read is issued.
- rnd_data, output, 8: render read data.
- rnd_valid, output, 1: one-cycle pulse; rnd_data is valid in this cycle.
- cpu_req, input, 1: CPU access strobe, one-cycle pulse.
- cpu_we, input, 1: CPU access type, 1 = write. Sampled with cpu_req.
- cpu_addr, input, 14: CPU address. Sampled with cpu_req.
- cpu_wdata, input, 8: CPU write data. Sampled with cpu_req.
- cpu_busy, output, 1: a CPU access is pending or in flight.
- cpu_rdata, output, 8: CPU read data. Held until the next CPU read completes.
- cpu_rvalid, output, 1: one-cycle pulse on CPU read completion.
- data_in, input, 8: memory read data.
- data_out, output, 8: memory write data.
- addr, output, 14: memory address.
- write_request, output, 1: memory write strobe, one cycle.
- read_request, output, 1: memory read strobe, one cycle.

Behaviour:
- Reset:
  - All outputs go to 0.
  - FSM goes to IDLE; the CPU pending latch and the starvation counter are cleared.
  - Reset during an access aborts it: no rnd_valid or cpu_rvalid pulse is produced and no write is issued.
- CPU latch:
  - cpu_req with cpu_busy=0 captures we, addr and wdata, and sets pending. cpu_busy goes high in the next cycle.
  - cpu_req while cpu_busy=1 is ignored.
  - A request captured in cycle N is eligible for arbitration from cycle N+1.
- Starvation counter:
  - Increments, saturating at 255, each cycle that pending=1 and the CPU is not granted.
  - Cleared when the CPU is granted.
- FSM states: IDLE, RD_WAIT, WR.
- IDLE arbitration decision, made in cycle G; priority order:
  1. pending and counter >= CPU_MAX_WAIT: grant the CPU.
  2. rnd_req: grant render.
  3. pending: grant the CPU.
  4. Otherwise stay in IDLE.
- Issue, all outputs registered, in cycle T = G+1:
  - Read: addr = grant address, read_request=1; FSM goes to RD_WAIT. For a render grant, rnd_ack=1 in cycle T.
  - CPU write: addr, data_out = wdata, write_request=1; FSM goes to WR.
- RD_WAIT:
  - Counts RD_LATENCY cycles and samples data_in in cycle T+RD_LATENCY.
  - In T+RD_LATENCY+1: rnd_data/rnd_valid or cpu_rdata/cpu_rvalid is produced; cpu_busy clears on a CPU read. FSM returns to IDLE.
- WR:
  - write_request lasts one cycle only.
  - In T+1: cpu_busy clears and FSM returns to IDLE.
- Throughput and overlap:
  - Arbitration happens only in IDLE, so back-to-back reads are spaced RD_LATENCY+2 cycles apart.
  - At most one access is in flight; no overlap.
- Strobe and output hold rules:
  - read_request and write_request are never high together.
  - data_out holds its last value except during a write.
  - addr holds its last value between accesses.
- Render requester obligations: may change rnd_addr or drop rnd_req in the cycle after rnd_ack.
- Simultaneous events:
  - rnd_req held while the CPU is pending: render wins until the counter reaches CPU_MAX_WAIT.
  - cpu_req arriving in the cycle the FSM returns to IDLE is latched and competes from the next cycle.

Optional Feature:
- Macro: PPU_PALETTE_MIRROR_EN.
- Defined:
  - Any address with addr[13:8]=6'h3F is folded to {6'h3F, 3'b000, a[4:0]} before issue.
  - Bit 4 is also cleared when a[1:0]=2'b00, so 3F10/3F14/3F18/3F1C map to 3F00/3F04/3F08/3F0C.
  - Applies to both requesters.
- Undefined: addresses pass through unmodified.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, FSM stays in IDLE.
- Render read: rnd_req with rnd_addr=14'h2000, memory model returns 8'hA5 after RD_LATENCY=2 -> read_request and rnd_ack one cycle after request, rnd_valid=1 with rnd_data=A5 three cycles later; single pulses only.
- CPU write: cpu_req with we=1, addr=14'h23C0, wdata=8'h5A -> write_request for exactly one cycle with addr=23C0 and data_out=5A, cpu_busy cleared the following cycle; a second cpu_req while busy produces no second write.
- Starvation: rnd_req held continuously, cpu_req read of addr 14'h0010, CPU_MAX_WAIT=8 -> render reads served until the counter reaches 8; the next grant is the CPU read, and cpu_rvalid fires with the model data.
- Reset mid-read: rst asserted in the cycle after read_request -> no rnd_valid pulse, all outputs 0, a fresh request afterwards behaves normally.
- With PPU_PALETTE_MIRROR_EN: CPU write to 3F10 -> addr=3F00; read of 3F25 -> addr=3F05. Without the macro: both addresses issued unchanged.
